// File: rtl/m24_arbiter.sv
// Shares one M24C08 EEPROM I2C bus between a boot reader (owns it once after reset)
// and a user engine, with an enforced idle gap between owners and a user grant timeout.
module m24_arbiter #(
  parameter int GAP_TICKS     = 8,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic SYSCLK_IN,
  input  logic RESET_N_IN,
  input  logic INT400K_IN,
  output logic BOOT_RESET_OUT,
  input  logic BOOT_BUSY_IN,
  input  logic BOOT_SCL_IN,
  input  logic BOOT_SDA_IN,
  input  logic BOOT_SDAT_IN,
  output logic BOOT_SDA_OUT,
  input  logic USR_REQ_IN,
  output logic USR_GNT_OUT,
  input  logic USR_DONE_IN,
  input  logic USR_SCL_IN,
  input  logic USR_SDA_IN,
  input  logic USR_SDAT_IN,
  output logic USR_SDA_OUT,
  output logic M24C08_SCL_OUT,
  output logic M24C08_SDA_OUT,
  output logic M24C08_SDAT_OUT,
  input  logic M24C08_SDA_IN,
  output logic BOOT_DONE_OUT,
  output logic TIMEOUT_OUT
);

  localparam logic [7:0]  GAP_LIMIT = 8'(GAP_TICKS);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {ST_BOOT, ST_GAP, ST_IDLE, ST_USER} state_t;

  state_t      state, state_nxt;
  logic        busy_q, busy_fall, usr_release, usr_timeout;
  logic [7:0]  gap_cnt;
  logic [15:0] tmo_cnt;
  logic        scl_q, sda_q, sdat_q, sda_in_q;
  logic        gnt_q, brst_q, tmo_q, done_q;
  logic        scl_d, sda_d, sdat_d, gnt_d, brst_d, tmo_d, done_d;

  assign busy_fall   = busy_q & ~BOOT_BUSY_IN;
  // A normal release (STOP or request dropped) takes priority over the timeout.
  assign usr_release = USR_DONE_IN | ~USR_REQ_IN;
  assign usr_timeout = (tmo_cnt == TMO_LIMIT) & ~usr_release;

  always_ff @(posedge SYSCLK_IN) begin
    if (!RESET_N_IN) state <= ST_BOOT;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: if (busy_fall) state_nxt = ST_GAP;
      ST_GAP:  if (gap_cnt == GAP_LIMIT) state_nxt = ST_IDLE;
      ST_IDLE: if (USR_REQ_IN && done_q) state_nxt = ST_USER;
      ST_USER: if (usr_release || usr_timeout) state_nxt = ST_GAP;
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Outputs are decoded from the upcoming state so grant and pin ownership switch together.
  always_comb begin
    scl_d  = 1'b1;
    sda_d  = 1'b1;
    sdat_d = 1'b1;
    case (state_nxt)
      ST_BOOT: begin
        scl_d  = BOOT_SCL_IN;
        sda_d  = BOOT_SDA_IN;
        sdat_d = BOOT_SDAT_IN;
      end
      ST_USER: begin
        scl_d  = USR_SCL_IN;
        sda_d  = USR_SDA_IN;
        sdat_d = USR_SDAT_IN;
      end
      default: ;
    endcase
    gnt_d  = (state_nxt == ST_USER);
    brst_d = (state_nxt != ST_BOOT);
    tmo_d  = (state == ST_USER) & usr_timeout;
    done_d = done_q | ((state == ST_BOOT) & busy_fall);
  end

  always_ff @(posedge SYSCLK_IN) begin
    if (!RESET_N_IN) begin
      busy_q  <= 1'b0;
      gap_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      busy_q <= BOOT_BUSY_IN;
      if (state != ST_GAP)
        gap_cnt <= '0;
      else if (INT400K_IN && gap_cnt != 8'hFF)
        gap_cnt <= gap_cnt + 8'd1;
      if (state != ST_USER)
        tmo_cnt <= '0;
      else if (INT400K_IN && tmo_cnt != 16'hFFFF)
        tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge SYSCLK_IN) begin
    if (!RESET_N_IN) begin
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      sdat_q   <= 1'b1;
      sda_in_q <= 1'b1;
      gnt_q    <= 1'b0;
      brst_q   <= 1'b1;
      tmo_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      sdat_q   <= sdat_d;
      sda_in_q <= M24C08_SDA_IN;
      gnt_q    <= gnt_d;
      brst_q   <= brst_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
    end
  end

  assign M24C08_SCL_OUT  = scl_q;
  assign M24C08_SDA_OUT  = sda_q;
  assign M24C08_SDAT_OUT = sdat_q;
  assign BOOT_SDA_OUT    = sda_in_q;
  assign USR_SDA_OUT     = sda_in_q;
  assign USR_GNT_OUT     = gnt_q;
  assign BOOT_RESET_OUT  = brst_q;
  assign TIMEOUT_OUT     = tmo_q;
  assign BOOT_DONE_OUT   = done_q;

endmodule

// File: tb/tb_m24_arbiter.sv
// Bench for m24_arbiter: bus-ownership model checked every cycle, directed boot/gap/timeout/reset
// scenarios with literal expectations, then a randomized phase.
module tb_m24_arbiter;

  localparam int GAP = 8;
  localparam int TMO = 4096;

  logic clk = 1'b0;
  logic rst_n, tick, busy, bscl, bsda, bsdat, req, udone, uscl, usda, usdat, sda_in;
  logic brst, bsda_ret, gnt, usda_ret, scl, sda, sdat, bdone, tmo;

  int checks = 0;
  int failures = 0;

  // Bus ownership model: 0 = boot reader, 1 = nobody, 2 = user engine.
  int   own = 0;
  bit   m_done, m_prev_busy, m_idle;
  int   m_gap_left, m_used;
  logic e_scl, e_sda, e_sdat, e_gnt, e_brst, e_tmo, e_bdone, e_ret;

  always #5 clk = ~clk;

  m24_arbiter #(.GAP_TICKS(GAP), .TIMEOUT_TICKS(TMO)) dut (
    .SYSCLK_IN(clk), .RESET_N_IN(rst_n), .INT400K_IN(tick),
    .BOOT_RESET_OUT(brst), .BOOT_BUSY_IN(busy),
    .BOOT_SCL_IN(bscl), .BOOT_SDA_IN(bsda), .BOOT_SDAT_IN(bsdat), .BOOT_SDA_OUT(bsda_ret),
    .USR_REQ_IN(req), .USR_GNT_OUT(gnt), .USR_DONE_IN(udone),
    .USR_SCL_IN(uscl), .USR_SDA_IN(usda), .USR_SDAT_IN(usdat), .USR_SDA_OUT(usda_ret),
    .M24C08_SCL_OUT(scl), .M24C08_SDA_OUT(sda), .M24C08_SDAT_OUT(sdat),
    .M24C08_SDA_IN(sda_in), .BOOT_DONE_OUT(bdone), .TIMEOUT_OUT(tmo)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  function automatic void release_bus();
    own = 1;
    m_idle = 1'b0;
    m_gap_left = GAP;
  endfunction

  // Advances the model using the inputs the DUT will sample at the coming edge.
  function automatic void model_update();
    e_tmo = 1'b0;
    if (!rst_n) begin
      own = 0; m_done = 1'b0; m_prev_busy = 1'b0;
      e_ret = 1'b1; e_scl = 1'b1; e_sda = 1'b1; e_sdat = 1'b1;
      e_gnt = 1'b0; e_brst = 1'b1; e_bdone = 1'b0;
      return;
    end
    e_ret = sda_in;
    case (own)
      0: if (m_prev_busy && !busy) begin m_done = 1'b1; release_bus(); end
      1: begin
        if (!m_idle) begin
          if (m_gap_left == 0) m_idle = 1'b1;
          else if (tick) m_gap_left--;
        end else if (req && m_done) begin
          own = 2; m_used = 0;
        end
      end
      default: begin
        if (udone || !req) release_bus();
        else if (m_used == TMO) begin e_tmo = 1'b1; release_bus(); end
        else if (tick) m_used++;
      end
    endcase
    m_prev_busy = busy;
    if (own == 0)      begin e_scl = bscl; e_sda = bsda; e_sdat = bsdat; end
    else if (own == 2) begin e_scl = uscl; e_sda = usda; e_sdat = usdat; end
    else               begin e_scl = 1'b1; e_sda = 1'b1; e_sdat = 1'b1; end
    e_gnt = (own == 2);
    e_brst = (own != 0);
    e_bdone = m_done;
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    chk("cycle_outputs",
        32'({brst, bdone, gnt, tmo, scl, sda, sdat, bsda_ret, usda_ret}),
        32'({e_brst, e_bdone, e_gnt, e_tmo, e_scl, e_sda, e_sdat, e_ret, e_ret}));
  endtask

  task automatic wait_gnt(input string name);
    int n = 0;
    while (gnt !== 1'b1 && n < 60) begin step(); n++; end
    chk(name, 32'(gnt), 1);
  endtask

  task automatic rand_inputs();
    rst_n = ($urandom_range(0, 599) != 0);
    if ($urandom_range(0, 29) == 0) busy = ~busy;
    if ($urandom_range(0, 7) == 0) req = ~req;
    tick  = 1'($urandom);
    udone = ($urandom_range(0, 39) == 0);
    bscl = 1'($urandom); bsda = 1'($urandom); bsdat = 1'($urandom);
    uscl = 1'($urandom); usda = 1'($urandom); usdat = 1'($urandom);
    sda_in = 1'($urandom);
  endtask

  initial begin
    int n;
    logic prev_scl;
    rst_n = 1'b0; tick = 1'b1; busy = 1'b0; req = 1'b1; udone = 1'b0;
    bscl = 1'b1; bsda = 1'b1; bsdat = 1'b1;
    uscl = 1'b1; usda = 1'b1; usdat = 1'b1; sda_in = 1'b1;
    step(); step();
    chk("reset_boot_rst", 32'(brst), 1);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_done", 32'(bdone), 0);
    chk("reset_pins", 32'({scl, sda, sdat, bsda_ret, usda_ret}), 32'h1f);

    rst_n = 1'b1;
    step();
    chk("boot_rst_low", 32'(brst), 0);
    busy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bscl = 1'($urandom); bsda = 1'($urandom); bsdat = 1'($urandom);
      uscl = 1'($urandom); usda = 1'($urandom); sda_in = 1'($urandom);
      step();
    end
    chk("boot_req_ignored", 32'(gnt), 0);

    bscl = 1'b1; bsda = 1'b1; bsdat = 1'b1;
    uscl = 1'b1; usda = 1'b1; usdat = 1'b1;
    busy = 1'b0;
    step();
    chk("boot_done_set", 32'(bdone), 1);
    chk("gap_pins", 32'({scl, sda, sdat, brst}), 32'hf);
    n = 0;
    while (gnt !== 1'b1 && n < 50) begin step(); n++; end
    chk("done_to_grant_cycles", n, 10);

    for (int i = 0; i < 20; i++) begin
      uscl = 1'($urandom); bscl = ~uscl;
      prev_scl = uscl;
      step();
      chk("scl_follows_user", 32'(scl), 32'(prev_scl));
    end

    req = 1'b0;
    step();
    chk("req_drop_gnt", 32'(gnt), 0);
    req = 1'b1; uscl = 1'b0; usda = 1'b0; usdat = 1'b0;
    wait_gnt("regrant_1");
    n = 1;
    while (gnt === 1'b1 && n < 5000) begin step(); if (gnt === 1'b1) n++; end
    chk("grant_len_to_timeout", n, TMO + 1);
    chk("timeout_pulse", 32'(tmo), 1);
    chk("timeout_pins", 32'({scl, sda, sdat}), 32'h7);
    step();
    chk("timeout_one_cycle", 32'(tmo), 0);

    wait_gnt("regrant_2");
    for (int i = 0; i < TMO; i++) step();
    udone = 1'b1;
    step();
    udone = 1'b0;
    chk("done_beats_timeout_tmo", 32'(tmo), 0);
    chk("done_beats_timeout_gnt", 32'(gnt), 0);

    wait_gnt("regrant_3");
    rst_n = 1'b0;
    step();
    chk("midreset_gnt", 32'(gnt), 0);
    chk("midreset_done", 32'(bdone), 0);
    chk("midreset_brst", 32'(brst), 1);
    chk("midreset_pins", 32'({scl, sda, sdat}), 32'h7);
    rst_n = 1'b1;
    step();
    chk("reboot_brst_low", 32'(brst), 0);

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
